// File: rtl/mioc_od_rx_filter.sv
// Receive-side filter for a pulled-up open-drain node: synchronizes, debounces, flags edges,
// counts completed low pulses and raises a sticky flag when the node stays low too long.
module mioc_od_rx_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1,
  input  logic             en,
  input  logic             clr,
  output logic             z,
  output logic             fall,
  output logic             rise,
  output logic [CNT_W-1:0] cnt,
  output logic             stuck
);

  typedef enum logic [1:0] {HIGH, QLOW, LOW, QHIGH} state_t;

  localparam logic [3:0]       FILT    = 4'(FILT_LEN);
  localparam logic [15:0]      TOUT    = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state, state_nx;
  logic [3:0]             qcnt, qcnt_nx, qcnt_inc;
  logic [15:0]            lcnt, lcnt_nx;
  logic [CNT_W-1:0]       cnt_nx;
  logic                   z_nx, fall_nx, rise_nx, stuck_nx;
  logic                   in_safe, s;
  logic [SYNC_STAGES-1:0] sync_q;

  // A floating or unknown node reads as the pull-up level.
  assign in_safe  = (in1 === 1'b0) ? 1'b0 : 1'b1;
  assign s        = sync_q[SYNC_STAGES-1];
  assign qcnt_inc = qcnt + 4'd1;

  always_comb begin
    state_nx = state;
    qcnt_nx  = qcnt;
    z_nx     = z;
    fall_nx  = 1'b0;
    rise_nx  = 1'b0;
    if (!en) begin
      qcnt_nx = 4'd0;
      if (state == QLOW)
        state_nx = HIGH;
      else if (state == QHIGH)
        state_nx = LOW;
    end else begin
      case (state)
        HIGH: if (!s) begin
          if (FILT == 4'd1) begin
            state_nx = LOW;
            z_nx     = 1'b0;
            fall_nx  = 1'b1;
            qcnt_nx  = 4'd0;
          end else begin
            state_nx = QLOW;
            qcnt_nx  = 4'd1;
          end
        end
        QLOW: if (!s) begin
          if (qcnt_inc == FILT) begin
            state_nx = LOW;
            z_nx     = 1'b0;
            fall_nx  = 1'b1;
            qcnt_nx  = 4'd0;
          end else begin
            qcnt_nx  = qcnt_inc;
          end
        end else begin
          state_nx = HIGH;
          qcnt_nx  = 4'd0;
        end
        LOW: if (s) begin
          if (FILT == 4'd1) begin
            state_nx = HIGH;
            z_nx     = 1'b1;
            rise_nx  = 1'b1;
            qcnt_nx  = 4'd0;
          end else begin
            state_nx = QHIGH;
            qcnt_nx  = 4'd1;
          end
        end
        QHIGH: if (s) begin
          if (qcnt_inc == FILT) begin
            state_nx = HIGH;
            z_nx     = 1'b1;
            rise_nx  = 1'b1;
            qcnt_nx  = 4'd0;
          end else begin
            qcnt_nx  = qcnt_inc;
          end
        end else begin
          state_nx = LOW;
          qcnt_nx  = 4'd0;
        end
        default: begin
          state_nx = HIGH;
          qcnt_nx  = 4'd0;
        end
      endcase
    end
  end

  // lcnt counts cycles already spent low; clr restarts it and wins over any count or flag update.
  always_comb begin
    lcnt_nx  = 16'd0;
    cnt_nx   = cnt;
    stuck_nx = stuck;
    if ((state == LOW || state == QHIGH) && state_nx != HIGH)
      lcnt_nx = (lcnt == TOUT) ? lcnt : lcnt + 16'd1;
    if (rise_nx && cnt != CNT_MAX)
      cnt_nx = cnt + 1'b1;
    if (lcnt_nx == TOUT)
      stuck_nx = 1'b1;
    if (clr) begin
      lcnt_nx  = 16'd0;
      cnt_nx   = '0;
      stuck_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      state  <= HIGH;
      qcnt   <= 4'd0;
      lcnt   <= 16'd0;
      z      <= 1'b1;
      fall   <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
      stuck  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_safe};
      state  <= state_nx;
      qcnt   <= qcnt_nx;
      lcnt   <= lcnt_nx;
      z      <= z_nx;
      fall   <= fall_nx;
      rise   <= rise_nx;
      cnt    <= cnt_nx;
      stuck  <= stuck_nx;
    end
  end

endmodule

// File: tb/tb_mioc_od_rx_filter.sv
// Directed bench for mioc_od_rx_filter: expectations are queued as stimulus is applied and
// popped when the outputs are sampled one time unit after each rising edge.
module tb_mioc_od_rx_filter;

  logic       clk;
  logic       rst;
  logic       in1;
  logic       en;
  logic       clr;
  logic       z, fall, rise, stuck;
  logic [7:0] cnt;
  logic       sat_z, sat_fall, sat_rise, sat_stuck;
  logic [1:0] sat_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   nChecks = 0;
  int   nPassed = 0;

  mioc_od_rx_filter dut (
    .clk(clk), .rst(rst), .in1(in1), .en(en), .clr(clr),
    .z(z), .fall(fall), .rise(rise), .cnt(cnt), .stuck(stuck)
  );

  mioc_od_rx_filter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in1(in1), .en(en), .clr(clr),
    .z(sat_z), .fall(sat_fall), .rise(sat_rise), .cnt(sat_cnt), .stuck(sat_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic in_v, input logic en_v, input logic clr_v);
    in1 = in_v;
    en  = en_v;
    clr = clr_v;
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    exp_t e;
    nChecks++;
    if (exp_q.size() == 0) begin
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) nPassed++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
    end
  endtask

  logic any_edge;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(2);
    pushExpect("rst_z", 1); pushExpect("rst_fall", 0); pushExpect("rst_rise", 0);
    pushExpect("rst_cnt", 0); pushExpect("rst_stuck", 0);
    checkOutput(z); checkOutput(fall); checkOutput(rise); checkOutput(cnt); checkOutput(stuck);
    rst = 1'b0;
    tick(3);

    // Basic pulse: fall on edge 5 after in1 drops, rise on edge 5 after it returns.
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExpect("a_z_e4", 1); pushExpect("a_fall_e4", 0);
    tick(4); checkOutput(z); checkOutput(fall);
    pushExpect("a_z_e5", 0); pushExpect("a_fall_e5", 1);
    tick(1); checkOutput(z); checkOutput(fall);
    pushExpect("a_fall_e6", 0);
    tick(1); checkOutput(fall);
    tick(4);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExpect("a_z_r4", 0); pushExpect("a_rise_r4", 0);
    tick(4); checkOutput(z); checkOutput(rise);
    pushExpect("a_z_r5", 1); pushExpect("a_rise_r5", 1); pushExpect("a_cnt_r5", 1);
    tick(1); checkOutput(z); checkOutput(rise); checkOutput(cnt);
    pushExpect("a_rise_r6", 0);
    tick(1); checkOutput(rise);

    // Two-sample glitch must be rejected.
    applyStimulus(1'b0, 1'b1, 1'b0);
    any_edge = 1'b0;
    tick(1); any_edge |= (z !== 1'b1) | fall | rise;
    tick(1); any_edge |= (z !== 1'b1) | fall | rise;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      any_edge |= (z !== 1'b1) | fall | rise;
    end
    pushExpect("glitch_activity", 0); pushExpect("glitch_cnt", 1);
    checkOutput(any_edge); checkOutput(cnt);

    // en=0 abandons qualification; re-enabling needs a full FILT_LEN run again.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(6);
    pushExpect("en_hold_z", 1);
    checkOutput(z);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExpect("en_requal_z2", 1);
    tick(2); checkOutput(z);
    pushExpect("en_requal_z3", 0); pushExpect("en_requal_fall", 1);
    tick(1); checkOutput(z); checkOutput(fall);
    applyStimulus(1'b1, 1'b0, 1'b0);
    any_edge = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      any_edge |= (z !== 1'b0) | fall | rise;
    end
    pushExpect("en_off_activity", 0);
    checkOutput(any_edge);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExpect("en_rise_z2", 0);
    tick(2); checkOutput(z);
    pushExpect("en_rise_z3", 1); pushExpect("en_rise", 1); pushExpect("en_cnt", 2);
    tick(1); checkOutput(z); checkOutput(rise); checkOutput(cnt);
    tick(2);

    // clr coincident with rise: the pulse is not counted.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(8);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pushExpect("clr_rise", 1); pushExpect("clr_cnt", 0);
    tick(1); checkOutput(rise); checkOutput(cnt);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExpect("clr_rise_next", 0); pushExpect("clr_cnt_next", 0);
    tick(1); checkOutput(rise); checkOutput(cnt);
    tick(2);

    // Saturation: the 2-bit counter stops at 3, the 8-bit one keeps going.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(6);
      applyStimulus(1'b1, 1'b1, 1'b0);
      pushExpect($sformatf("sat_cnt_%0d", i), (i > 3) ? 3 : i);
      pushExpect($sformatf("wide_cnt_%0d", i), i);
      tick(5);
      checkOutput(sat_cnt); checkOutput(cnt);
    end
    tick(2);

    // Stuck: sets after 64 cycles in LOW, survives release, cleared by clr.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(5);
    pushExpect("stuck_e63", 0);
    tick(63); checkOutput(stuck);
    pushExpect("stuck_e64", 1);
    tick(1); checkOutput(stuck);
    tick(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExpect("stuck_released_z", 1); pushExpect("stuck_released", 1);
    tick(8); checkOutput(z); checkOutput(stuck);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pushExpect("stuck_clr", 0); pushExpect("stuck_clr_cnt", 0);
    tick(1); checkOutput(stuck); checkOutput(cnt);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(2);

    // Reset during a low pulse: no rise, cnt zero, fall needs full latency again.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(6);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(6);
    pushExpect("pre_rst_cnt", 1);
    checkOutput(cnt);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(8);
    rst = 1'b1;
    pushExpect("midrst_z", 1); pushExpect("midrst_cnt", 0); pushExpect("midrst_rise", 0);
    tick(1); checkOutput(z); checkOutput(cnt); checkOutput(rise);
    rst = 1'b0;
    any_edge = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      any_edge |= (z !== 1'b1) | fall | rise;
    end
    pushExpect("postrst_quiet", 0);
    checkOutput(any_edge);
    pushExpect("postrst_z", 0); pushExpect("postrst_fall", 1); pushExpect("postrst_cnt", 0);
    tick(1); checkOutput(z); checkOutput(fall); checkOutput(cnt);

    pushExpect("queue_drained", 0);
    checkOutput(32'(exp_q.size() - 1));

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
